booth_seq_multiplier: RTL and testbench

//   Sequential radix-2 Booth multiplier for two's-complement operands.

---
 rtl/booth_seq_multiplier.sv | 108 ++++++++++
 tb/tb_booth_seq_multiplier.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per clock, 2*WIDTH signed product.
// Optional trace of the internal registers on step_* when BOOTH_STEP_TRACE_EN is defined.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic [2*WIDTH-1:0]           product,
  output logic [WIDTH-1:0]             step_a,
  output logic [WIDTH-1:0]             step_q,
  output logic                         step_q1,
  output logic [$clog2(WIDTH+1)-1:0]   step_cnt
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   m_reg;
  logic [AW-1:0]   acc;
  logic [WIDTH-1:0] q_reg;
  logic            q1;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]    sum_c;
  logic [AW-1:0]    acc_nxt_c;
  logic [WIDTH-1:0] q_nxt_c;
  logic             last_c;

  // Booth step datapath; A carries one guard bit so M = -2^(WIDTH-1) stays exact
  always_comb begin
    sum_c = acc;
    case ({q_reg[0], q1})
      2'b10:   sum_c = acc - m_reg;
      2'b01:   sum_c = acc + m_reg;
      default: sum_c = acc;
    endcase
    acc_nxt_c = {sum_c[AW-1], sum_c[AW-1:1]};
    q_nxt_c   = {sum_c[0], q_reg[WIDTH-1:1]};
    last_c    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      q1      <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg <= {b[WIDTH-1], b};
            acc   <= '0;
            q_reg <= a;
            q1    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt_c;
          q_reg <= q_nxt_c;
          q1    <= q_reg[0];
          cnt   <= cnt + CW'(1);
          // Final step: the shifted {A,Q} is the product
          if (last_c) begin
            product <= {acc_nxt_c[WIDTH-1:0], q_nxt_c};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOOTH_STEP_TRACE_EN
  assign step_a   = acc[WIDTH-1:0];
  assign step_q   = q_reg;
  assign step_q1  = q1;
  assign step_cnt = cnt;
`else
  assign step_a   = '0;
  assign step_q   = '0;
  assign step_q1  = 1'b0;
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (WIDTH=8) against an arithmetic reference model.
module tb_booth_seq_multiplier;

  localparam int unsigned W = 8;

`ifdef BOOTH_STEP_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   step_a;
  logic [W-1:0]   step_q;
  logic           step_q1;
  logic [3:0]     step_cnt;

  int checks = 0;
  int errors = 0;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .step_a(step_a), .step_q(step_q), .step_q1(step_q1), .step_cnt(step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return 16'(p);
  endfunction

  // After i Booth steps the upper register pair holds b * (low i bits of a, read as signed)
  function automatic longint partial(input logic [7:0] x, input logic [7:0] y, input int i);
    longint lo;
    lo = longint'(x) & ((longint'(1) << i) - 1);
    if (i > 0) begin
      if (x[i-1]) lo = lo - (longint'(1) << i);
    end
    return longint'($signed(y)) * lo;
  endfunction

  function automatic logic [7:0] ref_step_a(input logic [7:0] x, input logic [7:0] y, input int i);
    return 8'(partial(x, y, i) >>> i);
  endfunction

  function automatic logic [7:0] ref_step_q(input logic [7:0] x, input logic [7:0] y, input int i);
    longint p;
    p = partial(x, y, i) & ((longint'(1) << i) - 1);
    return 8'((p << (8 - i)) | (longint'(x) >> i));
  endfunction

  function automatic logic ref_step_q1(input logic [7:0] x, input int i);
    if (i == 0) return 1'b0;
    return x[i-1];
  endfunction

  // Launch one multiply and wait (bounded) for done; lat = edges from start edge, 20 = timeout
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, output int lat, output logic [15:0] p);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    p = '0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        p = product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'd5; b = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (product !== 16'h0) begin errors++; $display("FAIL reset_product got %h exp 0000", product); end
    checks++; if (step_a !== 8'h0) begin errors++; $display("FAIL reset_step_a got %h exp 00", step_a); end
    checks++; if (step_q !== 8'h0) begin errors++; $display("FAIL reset_step_q got %h exp 00", step_q); end
    checks++; if (step_q1 !== 1'b0) begin errors++; $display("FAIL reset_step_q1 got %b exp 0", step_q1); end
    checks++; if (step_cnt !== 4'h0) begin errors++; $display("FAIL reset_step_cnt got %0d exp 0", step_cnt); end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_trace();
    logic [7:0] x, y;
    x = 8'd100; y = 8'hF8;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL trace_busy_load got %b exp 1", busy); end
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      checks++;
      if (step_a !== (TRACE ? ref_step_a(x, y, i) : 8'h0)) begin
        errors++; $display("FAIL trace_step_a[%0d] got %h exp %h", i, step_a, TRACE ? ref_step_a(x, y, i) : 8'h0);
      end
      checks++;
      if (step_q !== (TRACE ? ref_step_q(x, y, i) : 8'h0)) begin
        errors++; $display("FAIL trace_step_q[%0d] got %h exp %h", i, step_q, TRACE ? ref_step_q(x, y, i) : 8'h0);
      end
      checks++;
      if (step_q1 !== (TRACE ? ref_step_q1(x, i) : 1'b0)) begin
        errors++; $display("FAIL trace_step_q1[%0d] got %b exp %b", i, step_q1, TRACE ? ref_step_q1(x, i) : 1'b0);
      end
      checks++;
      if (step_cnt !== (TRACE ? 4'(i) : 4'h0)) begin
        errors++; $display("FAIL trace_step_cnt[%0d] got %0d exp %0d", i, step_cnt, TRACE ? i : 0);
      end
      checks++;
      if (done !== (i == 8)) begin
        errors++; $display("FAIL trace_done[%0d] got %b exp %b", i, done, i == 8);
      end
    end
    checks++; if (product !== ref_mul(x, y)) begin errors++; $display("FAIL trace_product got %h exp %h", product, ref_mul(x, y)); end
    checks++; if (product !== 16'hFCE0) begin errors++; $display("FAIL trace_product_const got %h exp fce0", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trace_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_corners();
    logic [7:0] xs [7];
    logic [7:0] ys [7];
    int lat;
    logic [15:0] p;
    xs = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h7F};
    ys = '{8'h80, 8'h80, 8'hFB, 8'hFF, 8'hFF, 8'h7F, 8'h7F};
    for (int i = 0; i < 7; i++) begin
      do_op(xs[i], ys[i], lat, p);
      checks++; if (lat !== 8) begin errors++; $display("FAIL corner_latency[%0d] got %0d exp 8", i, lat); end
      checks++; if (p !== ref_mul(xs[i], ys[i])) begin errors++; $display("FAIL corner_product[%0d] a=%h b=%h got %h exp %h", i, xs[i], ys[i], p, ref_mul(xs[i], ys[i])); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] x1, y1;
    int nd, first_t;
    logic [15:0] pr;
    x1 = 8'd37; y1 = 8'hE9;
    nd = 0; first_t = -1; pr = '0;
    a = x1; b = y1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (first_t < 0) begin first_t = n; pr = product; end
      end
      if (n == 3) begin a = 8'h55; b = 8'h66; start = 1'b1; end
      if (n == 4) start = 1'b0;
    end
    checks++; if (nd !== 1) begin errors++; $display("FAIL busy_ignore_done_count got %0d exp 1", nd); end
    checks++; if (first_t !== 8) begin errors++; $display("FAIL busy_ignore_latency got %0d exp 8", first_t); end
    checks++; if (pr !== ref_mul(x1, y1)) begin errors++; $display("FAIL busy_ignore_product got %h exp %h", pr, ref_mul(x1, y1)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] x1, y1, x2, y2;
    int t [2];
    logic [15:0] pr [2];
    int n, nd;
    x1 = 8'hC3; y1 = 8'h5A; x2 = 8'h19; y2 = 8'h9C;
    t = '{-1, -1}; pr = '{16'h0, 16'h0};
    a = x1; b = y1; start = 1'b1;
    @(posedge clk); #1;
    a = x2; b = y2;
    n = 0; nd = 0;
    while (n < 40 && nd < 2) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        t[nd] = n; pr[nd] = product; nd++;
        if (nd == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++; if (t[0] !== 8) begin errors++; $display("FAIL b2b_first_latency got %0d exp 8", t[0]); end
    checks++; if (t[1] !== 17) begin errors++; $display("FAIL b2b_second_edge got %0d exp 17", t[1]); end
    checks++; if (pr[0] !== ref_mul(x1, y1)) begin errors++; $display("FAIL b2b_first_product got %h exp %h", pr[0], ref_mul(x1, y1)); end
    checks++; if (pr[1] !== ref_mul(x2, y2)) begin errors++; $display("FAIL b2b_second_product got %h exp %h", pr[1], ref_mul(x2, y2)); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int nd, lat;
    logic [15:0] p;
    a = 8'h6B; b = 8'hA1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
    checks++; if (product !== 16'h0) begin errors++; $display("FAIL midreset_product got %h exp 0000", product); end
    checks++; if (step_cnt !== 4'h0) begin errors++; $display("FAIL midreset_step_cnt got %0d exp 0", step_cnt); end
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", nd); end
    do_op(8'hF3, 8'h2D, lat, p);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midreset_restart_latency got %0d exp 8", lat); end
    checks++; if (p !== ref_mul(8'hF3, 8'h2D)) begin errors++; $display("FAIL midreset_restart_product got %h exp %h", p, ref_mul(8'hF3, 8'h2D)); end
  endtask

  task automatic test_random();
    logic [7:0] x, y;
    int lat;
    logic [15:0] p;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      do_op(x, y, lat, p);
      checks++; if (lat !== 8) begin errors++; $display("FAIL random_latency[%0d] got %0d exp 8", i, lat); end
      checks++; if (p !== ref_mul(x, y)) begin errors++; $display("FAIL random_product[%0d] a=%h b=%h got %h exp %h", i, x, y, p, ref_mul(x, y)); end
      checks++;
      if (step_cnt !== (TRACE ? 4'd8 : 4'd0)) begin
        errors++; $display("FAIL random_step_cnt[%0d] got %0d exp %0d", i, step_cnt, TRACE ? 8 : 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_trace();
    test_corners();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
